// File: rtl/lut_access_arbiter.sv
// lut_access_arbiter: shares one single-ported, synchronous-read lookup table RAM
// between the datapath lookup engine (priority, reads only) and the CPU
// register interface (reads and writes). One RAM access per cycle and a fixed
// three-cycle accept-to-response latency. A starvation counter forces a CPU
// slot after STARVE_LIMIT lost cycles.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   dp_req_*               datapath read request (ready is combinational)
//   dp_rsp_*               datapath read response, one-cycle valid pulse
//   cpu_req_*              CPU read/write request, held until accepted
//   cpu_rsp_*              CPU response pulse; rdata is 0 for a write ack
//   mem_*                  registered RAM strobes/address/data, mem_rdata in
//   o_cpu_forced           one-cycle pulse per forced CPU grant
module lut_access_arbiter #(
   parameter int unsigned ADDR_WIDTH   = 5,
   parameter int unsigned DATA_WIDTH   = 80,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  dp_req_valid,
   input  logic [ADDR_WIDTH-1:0] dp_req_addr,
   output logic                  dp_req_ready,
   output logic                  dp_rsp_valid,
   output logic [DATA_WIDTH-1:0] dp_rsp_data,
   input  logic                  cpu_req_valid,
   input  logic                  cpu_req_wr,
   input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
   input  logic [DATA_WIDTH-1:0] cpu_req_wdata,
   output logic                  cpu_req_ready,
   output logic                  cpu_rsp_valid,
   output logic [DATA_WIDTH-1:0] cpu_rsp_rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  o_cpu_forced
);

   localparam int unsigned STARVE_W = 8;

   typedef enum logic [1:0] {C_IDLE, C_WAIT, C_FORCE, C_PEND} cpu_state_e;

   // Owner tag travelling alongside each RAM access.
   typedef struct packed {
      logic vld;
      logic cpu;
      logic wr;
   } tag_t;

   cpu_state_e            state_q, state_d;
   logic [STARVE_W-1:0]   starve_q, starve_d;
   logic [STARVE_W-1:0]   starve_inc;
   tag_t                  tag1_q, tag1_d, tag2_q;
   logic                  forced_q, forced_d;
   logic                  mem_en_q, mem_we_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [DATA_WIDTH-1:0] mem_wdata_q;
   logic                  dp_rsp_valid_q, cpu_rsp_valid_q;
   logic [DATA_WIDTH-1:0] dp_rsp_data_q, cpu_rsp_rdata_q;
   logic                  cpu_grant, dp_grant;

   // Combinational handshakes; the two grants can never coincide.
   always_comb begin
      cpu_req_ready = cpu_req_valid & (state_q != C_PEND) &
                      (~dp_req_valid | (state_q == C_FORCE));
      dp_req_ready  = ~(cpu_req_valid & (state_q == C_FORCE));
      cpu_grant     = cpu_req_valid & cpu_req_ready;
      dp_grant      = dp_req_valid & dp_req_ready;
   end

   assign starve_inc = starve_q + STARVE_W'(1);

   // CPU FSM next state, starvation counter and access tag.
   // A lost cycle in C_IDLE already counts, so the CPU is granted in cycle
   // STARVE_LIMIT+1 of continuous datapath traffic.
   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      forced_d = 1'b0;
      tag1_d   = '0;

      unique case (state_q)
         C_IDLE, C_WAIT: begin
            if (cpu_grant) begin
               state_d  = C_PEND;
               starve_d = '0;
            end else if (cpu_req_valid) begin
               starve_d = starve_inc;
               state_d  = (starve_inc == STARVE_W'(STARVE_LIMIT)) ? C_FORCE : C_WAIT;
            end else begin
               state_d  = C_IDLE;
               starve_d = '0;
            end
         end
         C_FORCE: begin
            // A held request is always granted here; a dropped one returns to idle.
            state_d  = cpu_grant ? C_PEND : C_IDLE;
            starve_d = '0;
            forced_d = cpu_grant;
         end
         C_PEND: begin
            if (cpu_rsp_valid_q) state_d = C_IDLE;
         end
         default: state_d = C_IDLE;
      endcase

      if (cpu_grant)     tag1_d = '{vld: 1'b1, cpu: 1'b1, wr: cpu_req_wr};
      else if (dp_grant) tag1_d = '{vld: 1'b1, cpu: 1'b0, wr: 1'b0};
   end

   // State, RAM-side and response registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= C_IDLE;
         starve_q        <= '0;
         tag1_q          <= '0;
         tag2_q          <= '0;
         forced_q        <= 1'b0;
         mem_en_q        <= 1'b0;
         mem_we_q        <= 1'b0;
         mem_addr_q      <= '0;
         mem_wdata_q     <= '0;
         dp_rsp_valid_q  <= 1'b0;
         dp_rsp_data_q   <= '0;
         cpu_rsp_valid_q <= 1'b0;
         cpu_rsp_rdata_q <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         tag1_q   <= tag1_d;
         tag2_q   <= tag1_q;
         forced_q <= forced_d;
         mem_en_q <= cpu_grant | dp_grant;
         mem_we_q <= cpu_grant & cpu_req_wr;
         if (cpu_grant) begin
            mem_addr_q  <= cpu_req_addr;
            mem_wdata_q <= cpu_req_wdata;
         end else if (dp_grant) begin
            mem_addr_q  <= dp_req_addr;
         end
         // tag2 lines up with mem_rdata and steers it to its owner.
         dp_rsp_valid_q  <= tag2_q.vld & ~tag2_q.cpu;
         cpu_rsp_valid_q <= tag2_q.vld & tag2_q.cpu;
         if (tag2_q.vld & ~tag2_q.cpu) dp_rsp_data_q <= mem_rdata;
         if (tag2_q.vld & tag2_q.cpu)  cpu_rsp_rdata_q <= tag2_q.wr ? '0 : mem_rdata;
      end
   end

   assign dp_rsp_valid  = dp_rsp_valid_q;
   assign dp_rsp_data   = dp_rsp_data_q;
   assign cpu_rsp_valid = cpu_rsp_valid_q;
   assign cpu_rsp_rdata = cpu_rsp_rdata_q;
   assign mem_en        = mem_en_q;
   assign mem_we        = mem_we_q;
   assign mem_addr      = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;
   assign o_cpu_forced  = forced_q;

endmodule

// File: tb/tb_lut_access_arbiter.sv
// Bench for lut_access_arbiter: two instances (STARVE_LIMIT 8 and 1) share the
// request inputs, each with its own RAM model; sel picks the one under test.
// Drivers push expected responses (data and arrival cycle) into queues; a
// negedge monitor pops and compares whenever a response pulse appears.
module tb_lut_access_arbiter;

   typedef struct {
      logic [79:0] data;
      int unsigned cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        sel;
   logic        dp_req_valid;
   logic [4:0]  dp_req_addr;
   logic        cpu_req_valid;
   logic        cpu_req_wr;
   logic [4:0]  cpu_req_addr;
   logic [79:0] cpu_req_wdata;

   logic        a_dp_rdy, a_dp_rv, a_cpu_rdy, a_cpu_rv, a_en, a_we, a_frc;
   logic [79:0] a_dp_rd, a_cpu_rd, a_wd, a_rdata;
   logic [4:0]  a_addr;
   logic        b_dp_rdy, b_dp_rv, b_cpu_rdy, b_cpu_rv, b_en, b_we, b_frc;
   logic [79:0] b_dp_rd, b_cpu_rd, b_wd, b_rdata;
   logic [4:0]  b_addr;

   logic        dp_req_ready, dp_rsp_valid, cpu_req_ready, cpu_rsp_valid;
   logic        mem_en, mem_we, o_cpu_forced;
   logic [79:0] dp_rsp_data, cpu_rsp_rdata, mem_wdata;
   logic [4:0]  mem_addr;

   logic [79:0] ram_a [32];
   logic [79:0] ram_b [32];

   int unsigned cyc = 0;
   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned n_forced = 0;
   int unsigned n_stall = 0;
   int unsigned n_dp_rsp = 0;
   exp_t        dp_q[$];
   exp_t        cpu_q[$];
   exp_t        e_dp, e_cpu;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   lut_access_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(80), .STARVE_LIMIT(8)) u_dut8 (
      .clk(clk), .reset(reset),
      .dp_req_valid(dp_req_valid), .dp_req_addr(dp_req_addr), .dp_req_ready(a_dp_rdy),
      .dp_rsp_valid(a_dp_rv), .dp_rsp_data(a_dp_rd),
      .cpu_req_valid(cpu_req_valid), .cpu_req_wr(cpu_req_wr), .cpu_req_addr(cpu_req_addr),
      .cpu_req_wdata(cpu_req_wdata), .cpu_req_ready(a_cpu_rdy),
      .cpu_rsp_valid(a_cpu_rv), .cpu_rsp_rdata(a_cpu_rd),
      .mem_en(a_en), .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wd),
      .mem_rdata(a_rdata), .o_cpu_forced(a_frc));

   lut_access_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(80), .STARVE_LIMIT(1)) u_dut1 (
      .clk(clk), .reset(reset),
      .dp_req_valid(dp_req_valid), .dp_req_addr(dp_req_addr), .dp_req_ready(b_dp_rdy),
      .dp_rsp_valid(b_dp_rv), .dp_rsp_data(b_dp_rd),
      .cpu_req_valid(cpu_req_valid), .cpu_req_wr(cpu_req_wr), .cpu_req_addr(cpu_req_addr),
      .cpu_req_wdata(cpu_req_wdata), .cpu_req_ready(b_cpu_rdy),
      .cpu_rsp_valid(b_cpu_rv), .cpu_rsp_rdata(b_cpu_rd),
      .mem_en(b_en), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wd),
      .mem_rdata(b_rdata), .o_cpu_forced(b_frc));

   assign dp_req_ready  = sel ? b_dp_rdy  : a_dp_rdy;
   assign dp_rsp_valid  = sel ? b_dp_rv   : a_dp_rv;
   assign dp_rsp_data   = sel ? b_dp_rd   : a_dp_rd;
   assign cpu_req_ready = sel ? b_cpu_rdy : a_cpu_rdy;
   assign cpu_rsp_valid = sel ? b_cpu_rv  : a_cpu_rv;
   assign cpu_rsp_rdata = sel ? b_cpu_rd  : a_cpu_rd;
   assign mem_en        = sel ? b_en      : a_en;
   assign mem_we        = sel ? b_we      : a_we;
   assign mem_addr      = sel ? b_addr    : a_addr;
   assign mem_wdata     = sel ? b_wd      : a_wd;
   assign o_cpu_forced  = sel ? b_frc     : a_frc;

   // Single-port synchronous-read RAMs, one per instance.
   initial begin
      for (int i = 0; i < 32; i++) begin
         ram_a[i] = '0;
         ram_b[i] = '0;
      end
      a_rdata = '0;
      b_rdata = '0;
   end

   always @(posedge clk) begin
      if (a_en) begin
         if (a_we) ram_a[a_addr] <= a_wd;
         else      a_rdata <= ram_a[a_addr];
      end
      if (b_en) begin
         if (b_we) ram_b[b_addr] <= b_wd;
         else      b_rdata <= ram_b[b_addr];
      end
   end

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Response monitor and event counters.
   always @(negedge clk) begin
      if (!reset) begin
         if (o_cpu_forced) n_forced++;
         if (dp_req_valid && !dp_req_ready) n_stall++;
         if (dp_rsp_valid) begin
            n_dp_rsp++;
            if (dp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL dp_unexpected_rsp: got data %0h at cycle %0d, required no response", dp_rsp_data, cyc);
            end else begin
               e_dp = dp_q.pop_front();
               check("dp_rsp_data", dp_rsp_data, e_dp.data);
               check("dp_rsp_cycle", 80'(cyc), 80'(e_dp.cyc));
            end
         end
         if (cpu_rsp_valid) begin
            if (cpu_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL cpu_unexpected_rsp: got data %0h at cycle %0d, required no response", cpu_rsp_rdata, cyc);
            end else begin
               e_cpu = cpu_q.pop_front();
               check("cpu_rsp_rdata", cpu_rsp_rdata, e_cpu.data);
               check("cpu_rsp_cycle", 80'(cyc), 80'(e_cpu.cyc));
            end
         end
      end
   end

   // Datapath read; returns one cycle after acceptance with valid still high.
   task automatic dp_issue(input logic [4:0] a, input logic [79:0] exp);
      bit done = 1'b0;
      dp_req_valid = 1'b1;
      dp_req_addr  = a;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (dp_req_ready) begin
            dp_q.push_back('{data: exp, cyc: cyc + 3});
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (!done) begin
         n_vec++;
         n_err++;
         $display("FAIL dp_accept_timeout: got no accept in 40 cycles, required accept");
      end
   endtask

   task automatic dp_stream(input int n, input logic [4:0] a, input int n_old,
                            input logic [79:0] old_v, input logic [79:0] new_v);
      for (int i = 0; i < n; i++) dp_issue(a, (i < n_old) ? old_v : new_v);
      dp_req_valid = 1'b0;
   endtask

   task automatic cpu_issue(input logic wr, input logic [4:0] a, input logic [79:0] wd,
                            input logic [79:0] exp, output int unsigned acc_cyc);
      bit done = 1'b0;
      acc_cyc       = 0;
      cpu_req_valid = 1'b1;
      cpu_req_wr    = wr;
      cpu_req_addr  = a;
      cpu_req_wdata = wd;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (cpu_req_ready) begin
            check("cpu_single_outstanding", 80'(cpu_q.size()), 80'd0);
            cpu_q.push_back('{data: exp, cyc: cyc + 3});
            acc_cyc = cyc;
            done    = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      cpu_req_valid = 1'b0;
      if (!done) begin
         n_vec++;
         n_err++;
         $display("FAIL cpu_accept_timeout: got no accept in 40 cycles, required accept");
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && (dp_q.size() != 0 || cpu_q.size() != 0); i++) @(posedge clk);
      @(posedge clk);
      #1;
      check("drain_dp", 80'(dp_q.size()), 80'd0);
      check("drain_cpu", 80'(cpu_q.size()), 80'd0);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_dp_rsp_valid"}, 80'(dp_rsp_valid), 80'd0);
      check({tag, "_dp_rsp_data"}, dp_rsp_data, 80'd0);
      check({tag, "_cpu_rsp_valid"}, 80'(cpu_rsp_valid), 80'd0);
      check({tag, "_cpu_rsp_rdata"}, cpu_rsp_rdata, 80'd0);
      check({tag, "_mem_en"}, 80'(mem_en), 80'd0);
      check({tag, "_mem_we"}, 80'(mem_we), 80'd0);
      check({tag, "_mem_addr"}, 80'(mem_addr), 80'd0);
      check({tag, "_mem_wdata"}, mem_wdata, 80'd0);
      check({tag, "_forced"}, 80'(o_cpu_forced), 80'd0);
   endtask

   int unsigned t1, t2, s, f0, st0, r0;

   initial begin
      reset         = 1'b1;
      sel           = 1'b0;
      dp_req_valid  = 1'b0;
      dp_req_addr   = '0;
      cpu_req_valid = 1'b1;
      cpu_req_wr    = 1'b0;
      cpu_req_addr  = '0;
      cpu_req_wdata = '0;

      // Reset state and combinational readies.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_outputs_zero("reset");
      check("reset_dp_ready", 80'(dp_req_ready), 80'd1);
      check("reset_cpu_ready_v1", 80'(cpu_req_ready), 80'd1);
      cpu_req_valid = 1'b0;
      #1;
      check("reset_cpu_ready_v0", 80'(cpu_req_ready), 80'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Isolated accesses: write, datapath read, CPU read of addr 3.
      cpu_issue(1'b1, 5'd3, 80'h1234, 80'h0, t1);
      drain();
      dp_issue(5'd3, 80'h1234);
      dp_req_valid = 1'b0;
      drain();
      cpu_issue(1'b0, 5'd3, 80'h0, 80'h1234, t1);
      drain();

      // Priority with STARVE_LIMIT=8: 8 lost cycles, grant in the 9th.
      cpu_issue(1'b1, 5'd5, 80'hA5, 80'h0, t1);
      drain();
      f0 = n_forced;
      s  = cyc;
      fork
         dp_stream(12, 5'd3, 12, 80'h1234, 80'h1234);
         cpu_issue(1'b0, 5'd5, 80'h0, 80'hA5, t1);
      join
      check("prio_cpu_grant_offset", 80'(t1 - s), 80'd8);
      drain();
      check("prio_forced_count", 80'(n_forced - f0), 80'd1);

      // Single outstanding CPU access: back-to-back reads.
      s = cyc;
      cpu_issue(1'b0, 5'd3, 80'h0, 80'h1234, t1);
      cpu_issue(1'b0, 5'd5, 80'h0, 80'hA5, t2);
      check("b2b_first_offset", 80'(t1 - s), 80'd0);
      check("b2b_second_offset", 80'(t2 - s), 80'd4);
      drain();

      // Write ack under same-address datapath reads; reads 9.. see new data.
      s = cyc;
      fork
         dp_stream(14, 5'd7, 8, 80'h0, 80'hBEEF);
         cpu_issue(1'b1, 5'd7, 80'hBEEF, 80'h0, t1);
      join
      check("wack_cpu_grant_offset", 80'(t1 - s), 80'd8);
      drain();
      dp_issue(5'd7, 80'hBEEF);
      dp_req_valid = 1'b0;
      drain();

      // STARVE_LIMIT=1: grant in the 2nd cycle, one datapath stall.
      sel   = 1'b1;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      cpu_issue(1'b1, 5'd3, 80'h1234, 80'h0, t1);
      drain();
      f0  = n_forced;
      st0 = n_stall;
      s   = cyc;
      fork
         dp_stream(6, 5'd3, 6, 80'h1234, 80'h1234);
         cpu_issue(1'b0, 5'd3, 80'h0, 80'h1234, t1);
      join
      check("lim1_cpu_grant_offset", 80'(t1 - s), 80'd1);
      drain();
      check("lim1_forced_count", 80'(n_forced - f0), 80'd1);
      check("lim1_dp_stall_cycles", 80'(n_stall - st0), 80'd1);

      // Reset in the cycle after a datapath accept: no response may emerge.
      dp_req_valid = 1'b1;
      dp_req_addr  = 5'd3;
      @(negedge clk);
      check("rstmid_dp_ready", 80'(dp_req_ready), 80'd1);
      @(posedge clk);
      #1;
      dp_req_valid = 1'b0;
      reset        = 1'b1;
      @(negedge clk);
      check_outputs_zero("rstmid");
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      r0    = n_dp_rsp;
      repeat (6) @(negedge clk);
      check("rstmid_no_dp_rsp", 80'(n_dp_rsp - r0), 80'd0);
      check("rstmid_dp_ready_after", 80'(dp_req_ready), 80'd1);
      check("final_dp_queue", 80'(dp_q.size()), 80'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
